mono_data_tx_emu: RTL and testbench

- Synthesizable emulator of the Monopix pixel-matrix readout: the chip-side end of the token/read/freeze/serial-data interface.
- Software preloads 30-bit hit words over the 8-bit register bus. The block raises TX_TOKEN while hits are pending.
- On each TX_READ pulse it serializes one hit word, MSB first, on TX_DATA with its own divided serial clock TX_CLK.
- Used in loopback/self-test firmware builds and simulation benches to exercise the data receiver without a sensor.

---
 rtl/mono_data_tx_emu_if.sv | 27 ++
 rtl/mono_data_tx_emu.sv | 196 +++++++++++++++++++
 tb/tb_mono_data_tx_emu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mono_data_tx_emu_if.sv
// Register bus plus token/read/freeze/serial-data lines of the Monopix readout emulator.
// The slave side is the emulated chip; the master side is the bus host and receiver.
interface mono_data_tx_emu_if #(
  parameter int ABUSWIDTH = 16
);
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic [7:0]           BUS_DATA_OUT;
  logic                 BUS_WR;
  logic                 BUS_RD;
  logic                 TX_READ;
  logic                 TX_FREEZE;
  logic                 TX_TOKEN;
  logic                 TX_DATA;
  logic                 TX_CLK;
  logic                 BUSY;

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, TX_READ, TX_FREEZE,
    output BUS_DATA_OUT, TX_TOKEN, TX_DATA, TX_CLK, BUSY
  );

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD, TX_READ, TX_FREEZE,
    input  BUS_DATA_OUT, TX_TOKEN, TX_DATA, TX_CLK, BUSY
  );
endinterface

// File: rtl/mono_data_tx_emu.sv
// Monopix readout emulator: bus-loaded hit FIFO, token/freeze handling and
// MSB-first 30-bit serializer clocked by a divided TX_CLK.
module mono_data_tx_emu #(
  parameter int ABUSWIDTH  = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                  BUS_CLK,
  input  logic                  RST,
  mono_data_tx_emu_if.slave     bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_FALL = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, DONE} state_t;

  logic rst_i;
  assign rst_i = RST | (bus.BUS_WR & (bus.BUS_ADD == '0));

  // configuration and staging bytes
  logic       conf_en;
  logic [7:0] b2, b3, b4;
  always_ff @(posedge BUS_CLK) begin
    if (rst_i) begin
      conf_en <= 1'b0;
      b2 <= '0; b3 <= '0; b4 <= '0;
    end else if (bus.BUS_WR) begin
      case (bus.BUS_ADD)
        ABUSWIDTH'(1): conf_en <= bus.BUS_DATA_IN[0];
        ABUSWIDTH'(2): b2 <= bus.BUS_DATA_IN;
        ABUSWIDTH'(3): b3 <= bus.BUS_DATA_IN;
        ABUSWIDTH'(4): b4 <= bus.BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  // hit FIFO; a push into a full FIFO is accepted when a pop frees a slot the same cycle
  logic [29:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   fill;
  logic [7:0]            ovf_cnt;
  logic                  push, push_ok, pop, full;
  logic [29:0]           head;

  assign push    = ~rst_i & bus.BUS_WR & (bus.BUS_ADD == ABUSWIDTH'(5));
  assign full    = (fill == (DEPTH_LOG2+1)'(DEPTH));
  assign push_ok = push & (~full | pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge BUS_CLK) begin
    if (push_ok) mem[wr_ptr] <= {bus.BUS_DATA_IN[5:0], b4, b3, b2};
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      ovf_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
      if (push && !push_ok && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

  // receiver lines are asynchronous to BUS_CLK
  logic [1:0] read_s, freeze_s;
  logic       read_d, read_rise;
  always_ff @(posedge BUS_CLK) begin
    if (rst_i) begin
      read_s   <= '0;
      freeze_s <= '0;
      read_d   <= 1'b0;
    end else begin
      read_s   <= {read_s[0], bus.TX_READ};
      freeze_s <= {freeze_s[0], bus.TX_FREEZE};
      read_d   <= read_s[1];
    end
  end
  assign read_rise = read_s[1] & ~read_d;

  logic [CW-1:0] cnt;
  logic          fall_tick;
  always_ff @(posedge BUS_CLK) begin
    if (rst_i || !conf_en) cnt <= '0;
    else                   cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end
  assign fall_tick = conf_en & (cnt == CNT_FALL);

  logic token;
  always_ff @(posedge BUS_CLK) begin
    if (rst_i)            token <= 1'b0;
    else if (!freeze_s[1]) token <= conf_en & (fill != '0);
  end

  state_t      state, state_nx;
  logic [29:0] shreg, shreg_nx;
  logic [4:0]  bit_idx, bit_idx_nx;
  logic        tx_data, tx_data_nx;
  logic [7:0]  sent_cnt, sent_nx;

  always_ff @(posedge BUS_CLK) begin
    if (rst_i) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      tx_data  <= 1'b0;
      sent_cnt <= '0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_idx  <= bit_idx_nx;
      tx_data  <= tx_data_nx;
      sent_cnt <= sent_nx;
    end
  end

  // TX_DATA only moves on fall_tick, so it is stable across every TX_CLK rise
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    tx_data_nx = tx_data;
    sent_nx    = sent_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: if (read_rise && conf_en && fill != '0) state_nx = ARM;
      ARM: begin
        if (!conf_en) begin
          state_nx   = IDLE;
          tx_data_nx = 1'b0;
        end else if (fall_tick) begin
          shreg_nx   = head;
          pop        = 1'b1;
          bit_idx_nx = 5'd29;
          tx_data_nx = head[29];
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (!conf_en) begin
          state_nx   = IDLE;
          tx_data_nx = 1'b0;
        end else if (fall_tick) begin
          if (bit_idx == 5'd0) begin
            tx_data_nx = 1'b0;
            sent_nx    = sent_cnt + 8'd1;
            state_nx   = DONE;
          end else begin
            bit_idx_nx = bit_idx - 5'd1;
            tx_data_nx = shreg[bit_idx - 5'd1];
          end
        end
      end
      DONE: if (!read_s[1]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic [7:0] rd_mux, rd_q;
  always_comb begin
    rd_mux = 8'd0;
    case (bus.BUS_ADD)
      ABUSWIDTH'(0): rd_mux = 8'd1;
      ABUSWIDTH'(1): rd_mux = {7'd0, conf_en};
      ABUSWIDTH'(2): rd_mux = b2;
      ABUSWIDTH'(3): rd_mux = b3;
      ABUSWIDTH'(4): rd_mux = b4;
      ABUSWIDTH'(6): rd_mux = 8'(fill);
      ABUSWIDTH'(7): rd_mux = sent_cnt;
      ABUSWIDTH'(8): rd_mux = ovf_cnt;
      default:       rd_mux = 8'd0;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst_i)           rd_q <= '0;
    else if (bus.BUS_RD) rd_q <= rd_mux;
  end

  assign bus.BUS_DATA_OUT = rd_q;
  assign bus.TX_TOKEN     = token;
  assign bus.TX_DATA      = tx_data;
  assign bus.TX_CLK       = conf_en & (cnt < CNT_HALF);
  assign bus.BUSY         = (state == ARM) || (state == SHIFT);
endmodule

// File: tb/tb_mono_data_tx_emu.sv
// Randomized bench for mono_data_tx_emu: queue model of the hit FIFO and
// counters, serial words captured on TX_CLK rises and compared in order.
module tb_mono_data_tx_emu;
  localparam int ABW   = 16;
  localparam int DL    = 4;
  localparam int CD    = 4;
  localparam int DEPTH = 1 << DL;

  logic BUS_CLK = 1'b0;
  logic RST;
  always #5 BUS_CLK = ~BUS_CLK;

  mono_data_tx_emu_if #(.ABUSWIDTH(ABW)) bus();
  mono_data_tx_emu #(.ABUSWIDTH(ABW), .DEPTH_LOG2(DL), .CLK_DIV(CD)) dut (
    .BUS_CLK(BUS_CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [29:0] model_q[$];
  int          model_sent = 0;
  int          model_ovf  = 0;

  // serial capture: keep the last 30 bits seen while BUSY, publish a word when BUSY drops
  logic [29:0] rx_q[$];
  logic [29:0] rx_sh = '0;
  int          rx_nb = 0;
  bit          busy_seen = 1'b0;

  always @(posedge bus.TX_CLK) if (bus.BUSY === 1'b1) begin
    rx_sh = {rx_sh[28:0], bus.TX_DATA};
    rx_nb++;
  end
  always @(posedge bus.BUSY) begin
    rx_nb = 0;
    busy_seen = 1'b1;
  end
  always @(negedge bus.BUSY) if (rx_nb >= 30) rx_q.push_back(rx_sh);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge BUS_CLK);
    #1;
  endtask

  task automatic bus_write(input int addr, input logic [7:0] data);
    bus.BUS_ADD = ABW'(addr);
    bus.BUS_DATA_IN = data;
    bus.BUS_WR = 1'b1;
    tick();
    bus.BUS_WR = 1'b0;
  endtask

  task automatic bus_read(input int addr, output logic [7:0] data);
    bus.BUS_ADD = ABW'(addr);
    bus.BUS_RD = 1'b1;
    tick();
    bus.BUS_RD = 1'b0;
    data = bus.BUS_DATA_OUT;
  endtask

  task automatic push_word(input logic [29:0] w);
    bus_write(2, w[7:0]);
    bus_write(3, w[15:8]);
    bus_write(4, w[23:16]);
    bus_write(5, {2'($urandom), w[29:24]});
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else if (model_ovf < 255) model_ovf++;
  endtask

  task automatic drain_one(input string tag);
    logic [29:0] exp_w, got_w;
    int k;
    bus.TX_READ = 1'b1;
    tick($urandom_range(2, 10));
    bus.TX_READ = 1'b0;
    for (k = 0; k < 400 && rx_q.size() == 0; k++) tick();
    n_cmp++;
    if (rx_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: no word within 400 cycles, expected %h", tag, model_q[0]);
    end else begin
      got_w = rx_q.pop_front();
      exp_w = model_q.pop_front();
      model_sent = (model_sent + 1) % 256;
      if (got_w !== exp_w) begin
        n_err++;
        $display("FAIL %s: word got %h expected %h", tag, got_w, exp_w);
      end
    end
    tick(4);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    RST = 1'b1;
    bus.BUS_ADD = '0; bus.BUS_DATA_IN = '0; bus.BUS_WR = 1'b0; bus.BUS_RD = 1'b0;
    bus.TX_READ = 1'b0; bus.TX_FREEZE = 1'b0;
    tick(3);
    RST = 1'b0;
    tick();
    n_cmp++; if (bus.BUS_DATA_OUT !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h expected 00", bus.BUS_DATA_OUT); end
    n_cmp++; if ({bus.TX_TOKEN, bus.TX_DATA, bus.TX_CLK, bus.BUSY} !== 4'b0000) begin
      n_err++; $display("FAIL rst_outs: got tok/dat/clk/busy=%b expected 0000", {bus.TX_TOKEN, bus.TX_DATA, bus.TX_CLK, bus.BUSY}); end
    bus_read(0, d); n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL version: got %h expected 01", d); end
    bus_read(6, d); n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_fill: got %h expected 00", d); end
    bus_read(7, d); n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_sent: got %h expected 00", d); end
    bus_read(8, d); n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL rst_ovf: got %h expected 00", d); end
  endtask

  task automatic test_single;
    logic [7:0] d;
    bus_write(1, 8'h01);
    push_word(30'h2AAAAAAA);
    tick(2);
    n_cmp++; if (bus.TX_TOKEN !== 1'b1) begin n_err++; $display("FAIL single_token: got %b expected 1", bus.TX_TOKEN); end
    bus_read(6, d); n_cmp++; if (d !== 8'd1) begin n_err++; $display("FAIL single_fill: got %0d expected 1", d); end
    drain_one("single_word");
    bus_read(6, d); n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL single_fill0: got %0d expected 0", d); end
    bus_read(7, d); n_cmp++; if (d !== 8'(model_sent)) begin n_err++; $display("FAIL single_sent: got %0d expected %0d", d, model_sent); end
    n_cmp++; if (bus.TX_TOKEN !== 1'b0) begin n_err++; $display("FAIL single_token0: got %b expected 0", bus.TX_TOKEN); end
  endtask

  task automatic test_overflow_drain;
    logic [7:0] d;
    for (int i = 0; i < DEPTH + 1; i++) push_word(30'($urandom));
    bus_read(6, d); n_cmp++; if (d !== 8'(model_q.size())) begin n_err++; $display("FAIL ovf_fill: got %0d expected %0d", d, model_q.size()); end
    bus_read(8, d); n_cmp++; if (d !== 8'(model_ovf)) begin n_err++; $display("FAIL ovf_cnt: got %0d expected %0d", d, model_ovf); end
    while (model_q.size() != 0) drain_one("drain_word");
    bus_read(7, d); n_cmp++; if (d !== 8'(model_sent)) begin n_err++; $display("FAIL drain_sent: got %0d expected %0d", d, model_sent); end
    bus_read(6, d); n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL drain_fill: got %0d expected 0", d); end
  endtask

  task automatic test_freeze;
    int k;
    bus.TX_FREEZE = 1'b1;
    tick(4);
    push_word(30'($urandom));
    tick(6);
    n_cmp++; if (bus.TX_TOKEN !== 1'b0) begin n_err++; $display("FAIL freeze_hold: got %b expected 0", bus.TX_TOKEN); end
    bus.TX_FREEZE = 1'b0;
    for (k = 0; k < 3 && bus.TX_TOKEN !== 1'b1; k++) tick();
    n_cmp++; if (bus.TX_TOKEN !== 1'b1) begin n_err++; $display("FAIL freeze_release: got %b expected 1", bus.TX_TOKEN); end
    drain_one("freeze_word");
  endtask

  task automatic test_empty_and_hold;
    logic [7:0] d;
    busy_seen = 1'b0;
    bus.TX_READ = 1'b1;
    tick($urandom_range(3, 8));
    bus.TX_READ = 1'b0;
    tick(100);
    n_cmp++; if (busy_seen !== 1'b0 || rx_q.size() != 0) begin
      n_err++; $display("FAIL empty_read: got busy_seen=%b words=%0d expected 0 0", busy_seen, rx_q.size()); end
    bus_read(7, d); n_cmp++; if (d !== 8'(model_sent)) begin n_err++; $display("FAIL empty_sent: got %0d expected %0d", d, model_sent); end
    push_word(30'($urandom));
    push_word(30'($urandom));
    bus.TX_READ = 1'b1;
    tick(400);
    n_cmp++;
    if (rx_q.size() != 1) begin
      n_err++; $display("FAIL hold_count: got %0d words expected 1", rx_q.size());
    end else begin
      logic [29:0] g, e;
      g = rx_q.pop_front();
      e = model_q.pop_front();
      model_sent = (model_sent + 1) % 256;
      n_cmp++; if (g !== e) begin n_err++; $display("FAIL hold_word: got %h expected %h", g, e); end
    end
    rx_q.delete();
    bus_read(6, d); n_cmp++; if (d !== 8'(model_q.size())) begin n_err++; $display("FAIL hold_fill: got %0d expected %0d", d, model_q.size()); end
    bus.TX_READ = 1'b0;
    tick(4);
    drain_one("hold_second");
  endtask

  task automatic test_soft_reset;
    logic [7:0] d;
    int k;
    push_word(30'h3FFFFFFF);
    bus.TX_READ = 1'b1;
    tick(3);
    bus.TX_READ = 1'b0;
    for (k = 0; k < 300 && !(bus.BUSY === 1'b1 && rx_nb >= 16); k++) tick();
    n_cmp++; if (k >= 300) begin n_err++; $display("FAIL srst_reach: got timeout expected bit 15 reached"); end
    bus_write(0, 8'h00);
    model_q.delete(); model_sent = 0; model_ovf = 0;
    n_cmp++; if (bus.TX_DATA !== 1'b0 || bus.BUSY !== 1'b0) begin
      n_err++; $display("FAIL srst_outs: got data=%b busy=%b expected 0 0", bus.TX_DATA, bus.BUSY); end
    bus_read(6, d); n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL srst_fill: got %0d expected 0", d); end
    bus_read(7, d); n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL srst_sent: got %0d expected 0", d); end
    bus_read(8, d); n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL srst_ovf: got %0d expected 0", d); end
    bus_read(1, d); n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL srst_conf: got %0d expected 0", d); end
    tick(200);
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL srst_noword: got %0d words expected 0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow_drain();
    test_freeze();
    test_empty_and_hold();
    test_soft_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
